// File: rtl/evg_pkg.sv
// rtl/evg_pkg.sv - event codes, TOD FSM states and counter helper for the event arbiter
package evg_pkg;

  localparam logic [7:0] EVCODE_IDLE         = 8'h00;
  localparam logic [7:0] EVCODE_TOD0         = 8'h70;
  localparam logic [7:0] EVCODE_TOD1         = 8'h71;
  localparam logic [7:0] EVCODE_HEARTBEAT    = 8'h7A;
  localparam logic [7:0] EVCODE_SECONDS_MARK = 8'h7D;

  typedef enum logic [1:0] {
    TOD_IDLE,
    TOD_WAIT_MARK,
    TOD_SHIFT
  } tod_state_t;

  // Several merge/defer events can land in one cycle, so the increment is multi-bit.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/evg_event_arbiter_if.sv
// rtl/evg_event_arbiter_if.sv - source streams, strobes and framer-side outputs of the event arbiter
interface evg_event_arbiter_if #(
  parameter int TOD_SECONDS_WIDTH = 32
);
  logic [7:0]                   evgSequenceEventTDATA;
  logic                         evgSequenceEventTVALID;
  logic [7:0]                   evgHardwareEventTDATA;
  logic                         evgHardwareEventTVALID;
  logic                         evgHardwareEventTREADY;
  logic [7:0]                   evgSoftwareEventTDATA;
  logic                         evgSoftwareEventTVALID;
  logic                         evgSoftwareEventTREADY;
  logic                         evgHeartbeatRequest;
  logic                         evgPpsStrobe;
  logic [TOD_SECONDS_WIDTH-1:0] evgSecondsNext;
  logic [7:0]                   evgEventCode;
  logic                         evgEventValid;
  logic [15:0]                  evgMergeCount;
  logic [15:0]                  evgDeferCount;

  modport master (
    output evgSequenceEventTDATA, evgSequenceEventTVALID,
    output evgHardwareEventTDATA, evgHardwareEventTVALID,
    input  evgHardwareEventTREADY,
    output evgSoftwareEventTDATA, evgSoftwareEventTVALID,
    input  evgSoftwareEventTREADY,
    output evgHeartbeatRequest, evgPpsStrobe, evgSecondsNext,
    input  evgEventCode, evgEventValid, evgMergeCount, evgDeferCount
  );

  modport slave (
    input  evgSequenceEventTDATA, evgSequenceEventTVALID,
    input  evgHardwareEventTDATA, evgHardwareEventTVALID,
    output evgHardwareEventTREADY,
    input  evgSoftwareEventTDATA, evgSoftwareEventTVALID,
    output evgSoftwareEventTREADY,
    input  evgHeartbeatRequest, evgPpsStrobe, evgSecondsNext,
    output evgEventCode, evgEventValid, evgMergeCount, evgDeferCount
  );
endinterface

// File: rtl/evg_tod_shifter.sv
// rtl/evg_tod_shifter.sv - TOD seconds serialiser FSM; abort output exists only with EVG_ARB_STATS_EN
module evg_tod_shifter
  import evg_pkg::*;
#(
  parameter int TOD_SECONDS_WIDTH = 32,
  parameter int TOD_BIT_SPACING   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_pps_strobe,
  input  logic [TOD_SECONDS_WIDTH-1:0] i_seconds_next,
  input  logic                         i_mark_grant,
  input  logic                         i_bit_grant,
  output logic                         o_bit_req,
`ifdef EVG_ARB_STATS_EN
  output logic                         o_abort,
`endif
  output logic                         o_bit_value
);

  localparam int CW = $clog2(TOD_SECONDS_WIDTH + 1);
  localparam int SW = (TOD_BIT_SPACING > 1) ? $clog2(TOD_BIT_SPACING) : 1;

  tod_state_t                   r_state;
  logic [TOD_SECONDS_WIDTH-1:0] r_shift;
  logic [CW-1:0]                r_bits_left;
  logic [SW-1:0]                r_space;

  assign o_bit_req   = (r_state == TOD_SHIFT) && (r_space == '0);
  assign o_bit_value = r_shift[TOD_SECONDS_WIDTH-1];
`ifdef EVG_ARB_STATS_EN
  assign o_abort     = i_pps_strobe && (r_state != TOD_IDLE);
`endif

  // A new PPS always wins: any bits still pending belong to a stale second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= TOD_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_space     <= '0;
    end else if (i_pps_strobe) begin
      r_state     <= TOD_WAIT_MARK;
      r_shift     <= i_seconds_next;
      r_bits_left <= CW'(TOD_SECONDS_WIDTH);
      r_space     <= '0;
    end else begin
      case (r_state)
        TOD_WAIT_MARK: begin
          if (i_mark_grant) begin
            r_state <= TOD_SHIFT;
            r_space <= '0;
          end
        end
        TOD_SHIFT: begin
          if (i_bit_grant) begin
            r_shift     <= r_shift << 1;
            r_bits_left <= r_bits_left - 1'b1;
            r_space     <= SW'(TOD_BIT_SPACING - 1);
            if (r_bits_left == CW'(1)) r_state <= TOD_IDLE;
          end else if (r_space != '0) begin
            r_space <= r_space - 1'b1;
          end
        end
        default: r_state <= TOD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/evg_event_arbiter.sv
// rtl/evg_event_arbiter.sv - per-cycle event slot arbiter; EVG_ARB_STATS_EN enables merge/defer counters
module evg_event_arbiter
  import evg_pkg::*;
#(
  parameter int TOD_SECONDS_WIDTH = 32,
  parameter int TOD_BIT_SPACING   = 4
) (
  input  logic              evgTxClk,
  input  logic              evgTxReset,
  evg_event_arbiter_if.slave bus
);

  logic       r_pps_pending;
  logic       r_hb_pending;
  logic       r_rr_last_hw;
  logic [7:0] r_code;
  logic       r_valid;

  logic       w_seq_req;
  logic       w_hw_v;
  logic       w_sw_v;
  logic       w_tod_req;
  logic       w_tod_bit;
  logic [7:0] w_code;
  logic       w_grant_pps;
  logic       w_grant_hb;
  logic       w_grant_hw;
  logic       w_grant_sw;
  logic       w_grant_tod;

  assign w_seq_req = bus.evgSequenceEventTVALID && (bus.evgSequenceEventTDATA != EVCODE_IDLE);
  assign w_hw_v    = bus.evgHardwareEventTVALID;
  assign w_sw_v    = bus.evgSoftwareEventTVALID;

  always_comb begin
    w_code      = EVCODE_IDLE;
    w_grant_pps = 1'b0;
    w_grant_hb  = 1'b0;
    w_grant_hw  = 1'b0;
    w_grant_sw  = 1'b0;
    w_grant_tod = 1'b0;
    if (w_seq_req) begin
      w_code = bus.evgSequenceEventTDATA;
    end else if (r_pps_pending) begin
      w_code      = EVCODE_SECONDS_MARK;
      w_grant_pps = 1'b1;
    end else if (r_hb_pending) begin
      w_code     = EVCODE_HEARTBEAT;
      w_grant_hb = 1'b1;
    end else if (w_hw_v && (!w_sw_v || !r_rr_last_hw)) begin
      w_code     = bus.evgHardwareEventTDATA;
      w_grant_hw = 1'b1;
    end else if (w_sw_v) begin
      w_code     = bus.evgSoftwareEventTDATA;
      w_grant_sw = 1'b1;
    end else if (w_tod_req) begin
      w_code      = w_tod_bit ? EVCODE_TOD1 : EVCODE_TOD0;
      w_grant_tod = 1'b1;
    end
  end

  assign bus.evgHardwareEventTREADY = w_grant_hw;
  assign bus.evgSoftwareEventTREADY = w_grant_sw;
  assign bus.evgEventCode           = r_code;
  assign bus.evgEventValid          = r_valid;

`ifdef EVG_ARB_STATS_EN
  logic w_tod_abort;
`endif

  evg_tod_shifter #(
    .TOD_SECONDS_WIDTH(TOD_SECONDS_WIDTH),
    .TOD_BIT_SPACING  (TOD_BIT_SPACING)
  ) u_tod (
    .clk           (evgTxClk),
    .rst           (evgTxReset),
    .i_pps_strobe  (bus.evgPpsStrobe),
    .i_seconds_next(bus.evgSecondsNext),
    .i_mark_grant  (w_grant_pps),
    .i_bit_grant   (w_grant_tod),
    .o_bit_req     (w_tod_req),
`ifdef EVG_ARB_STATS_EN
    .o_abort       (w_tod_abort),
`endif
    .o_bit_value   (w_tod_bit)
  );

  // A strobe coinciding with its own grant simply re-arms the flag.
  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      r_pps_pending <= 1'b0;
      r_hb_pending  <= 1'b0;
      r_rr_last_hw  <= 1'b1;
      r_code        <= EVCODE_IDLE;
      r_valid       <= 1'b0;
    end else begin
      r_pps_pending <= bus.evgPpsStrobe || (r_pps_pending && !w_grant_pps);
      r_hb_pending  <= bus.evgHeartbeatRequest || (r_hb_pending && !w_grant_hb);
      r_code        <= w_code;
      r_valid       <= (w_code != EVCODE_IDLE);
      if (w_hw_v && w_sw_v && (w_grant_hw || w_grant_sw)) r_rr_last_hw <= w_grant_hw;
    end
  end

`ifdef EVG_ARB_STATS_EN
  logic [15:0] r_merge_count;
  logic [15:0] r_defer_count;
  logic [1:0]  w_merge_inc;
  logic [1:0]  w_defer_inc;

  assign w_merge_inc = {1'b0, bus.evgPpsStrobe && r_pps_pending && !w_grant_pps}
                     + {1'b0, bus.evgHeartbeatRequest && r_hb_pending && !w_grant_hb}
                     + {1'b0, w_tod_abort};
  assign w_defer_inc = {1'b0, w_hw_v && !w_grant_hw} + {1'b0, w_sw_v && !w_grant_sw};

  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      r_merge_count <= '0;
      r_defer_count <= '0;
    end else begin
      r_merge_count <= sat_add16(r_merge_count, w_merge_inc);
      r_defer_count <= sat_add16(r_defer_count, w_defer_inc);
    end
  end

  assign bus.evgMergeCount = r_merge_count;
  assign bus.evgDeferCount = r_defer_count;
`else
  assign bus.evgMergeCount = 16'h0000;
  assign bus.evgDeferCount = 16'h0000;
`endif

endmodule

// File: doc/evg_event_arbiter.md
# evg_event_arbiter

Single-clock event-slot arbiter for the event generator transmit path. Every `evgTxClk` cycle it picks at most one event code from the following sources, in priority order:

- sequencer events
- PPS seconds-marker
- heartbeat
- hardware/software trigger FIFOs
- time-of-day seconds shifter

It presents the chosen code to the 8b/10b framer. It owns PPS/heartbeat pending flags, round-robin fairness between trigger sources, and serialisation of the next-seconds value as 0x70/0x71 bit events.

## Interface
Parameters:
- TOD_SECONDS_WIDTH, 32, seconds bits shifted per PPS
- TOD_BIT_SPACING, 4, minimum cycles between successive TOD bit events (≥1)

Ports (all in `evgTxClk` domain):
- evgTxClk  in  1  transmit clock
- evgTxReset  in  1  reset, asynchronous assert, active-high
- evgSequenceEventTDATA  in  8  sequencer code; no backpressure
- evgSequenceEventTVALID  in  1  sequencer code valid
- evgHardwareEventTDATA  in  8  hardware trigger code
- evgHardwareEventTVALID  in  1  hardware code valid
- evgHardwareEventTREADY  out  1  hardware code consumed this cycle
- evgSoftwareEventTDATA  in  8  software trigger code
- evgSoftwareEventTVALID  in  1  software code valid
- evgSoftwareEventTREADY  out  1  software code consumed this cycle
- evgHeartbeatRequest  in  1  single-cycle heartbeat strobe
- evgPpsStrobe  in  1  single-cycle PPS strobe
- evgSecondsNext  in  TOD_SECONDS_WIDTH  seconds value sampled on evgPpsStrobe
- evgEventCode  out  8  registered event code; 0x00 = idle
- evgEventValid  out  1  evgEventCode non-idle
- evgMergeCount  out  16  merged/aborted request counter (stats)
- evgDeferCount  out  16  trigger-defer counter (stats)

## Operation
- **Slot ownership:** one event slot per cycle.
- **Sequencer:** TVALID with TDATA≠0 always wins. TVALID with TDATA=0 is treated as no request.
- **PPS and heartbeat:**
  - Strobes set `ppsPending` / `hbPending`.
  - A strobe arriving while its flag is already set merges into it and increments evgMergeCount.
  - Granted codes: PPS → 0x7D, heartbeat → 0x7A. The flag clears on grant.
  - A strobe in the same cycle as its grant re-sets the flag; no merge is counted.
- **Triggers:**
  - Hardware and software sources share one slot by round-robin.
  - The last-served pointer toggles only when the other source was also valid.
  - TREADY is asserted combinationally only in the grant cycle. It never depends on TDATA.
  - A trigger source whose TVALID is high but is not granted increments evgDeferCount once per cycle.
- **TOD FSM:** states IDLE → WAIT_MARK → SHIFT → IDLE.
  - evgPpsStrobe latches evgSecondsNext into a shift register and loads `bitsLeft` = TOD_SECONDS_WIDTH.
  - The FSM then enters WAIT_MARK.
  - When 0x7D is granted, the FSM enters SHIFT.
  - In SHIFT, the lowest priority slot is requested only once the spacing counter reaches 0. Each grant:
    - emits 0x70 (MSB=0) or 0x71 (MSB=1),
    - shifts the register left,
    - decrements `bitsLeft`,
    - reloads the spacing counter with TOD_BIT_SPACING−1.
  - When `bitsLeft` reaches 0 the FSM returns to IDLE.
- **PPS during WAIT_MARK or SHIFT:**
  - Remaining bits are abandoned and evgMergeCount increments.
  - The shift register reloads and the FSM enters WAIT_MARK.
- **Counters:** saturate at 0xFFFF.
- **Reset values:** all outputs 0, flags clear, FSM IDLE, RR pointer = hardware-last (software served first on a tie).

## Timing
- A grant in cycle N drives evgEventCode/evgEventValid in cycle N+1.
- TREADY and grant are in the same cycle as the handshake.
- A PPS strobe in cycle N can be granted in cycle N+1 at the earliest. The first TOD bit follows no earlier than the cycle after the 0x7D grant.
- **Heartbeat starvation:** heartbeat is starved only while sequencer or PPS win. The trigger and TOD sources cannot delay it.
- **Reset:** reset asserted mid-shift immediately aborts the FSM. No partial code is emitted after reset releases.

## Configuration
- EVG_ARB_STATS_EN
  - Defined: evgMergeCount and evgDeferCount count as specified.
  - Undefined: both outputs are constant 0. Their counter logic is removed. Arbitration behaviour is identical.

## Structure
- Shared package `evg_pkg` holds:
  - event-code constants: EVCODE_IDLE 0x00, EVCODE_TOD0 0x70, EVCODE_TOD1 0x71, EVCODE_HEARTBEAT 0x7A, EVCODE_SECONDS_MARK 0x7D
  - the TOD FSM state enum
- One sub-module: `evg_tod_shifter`, containing the FSM, shift register, bit counter and spacing counter. It has a request/grant interface to the arbiter core.

## Test plan
- Sequencer 0x20 and hardware 0x30 valid in the same cycle → 0x20 in N+1. Hardware TREADY stays low; 0x30 goes out in N+2; evgDeferCount = 1.
- Hardware and software valid continuously with codes 0x11/0x22 → output alternates 0x22, 0x11, 0x22, … Each TREADY pulses every other cycle.
- PPS with evgSecondsNext = 0x80000001, no other traffic, spacing 4 → 0x7D, then 0x71, thirty × 0x70, 0x71. Bits are 4 cycles apart; FSM ends in IDLE.
- Heartbeat strobed twice before grant, because a sequencer burst blocks it → single 0x7A after the burst; evgMergeCount = 1.
- PPS re-strobed after 10 TOD bits → a new 0x7D, then a full 32-bit shift of the new value; evgMergeCount increments.
- Reset asserted mid-shift → outputs 0 asynchronously. After release, no 0x70/0x71 appears until the next PPS.
